// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared mode and bounce-direction encodings for the LED pattern engine
package led_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_BLINK  = 2'd0;
    localparam mode_t MODE_ROTATE = 2'd1;
    localparam mode_t MODE_BOUNCE = 2'd2;
    localparam mode_t MODE_FILL   = 2'd3;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - parametrised LED pattern engine: blink, rotate, bounce, fill/drain
// Steps once every DWELL enabled ticks; wrap pulses when a pattern period completes.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DWELL = 1
) (
    input  logic             clk_now,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             dir,
    output logic [WIDTH-1:0] led,
    output logic             wrap
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int PW = $clog2(WIDTH);

    localparam logic [CW-1:0]    CNT_LAST = CW'(DWELL - 1);
    localparam logic [PW-1:0]    POS_LAST = PW'(WIDTH - 1);
    localparam logic [PW-1:0]    POS_ONE  = PW'(1);
    localparam logic [WIDTH-1:0] LED_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] LED_ONE  = WIDTH'(1);

    logic [WIDTH-1:0] r_led;
    logic             r_wrap;
    mode_t            r_mode_q;
    logic [CW-1:0]    r_dwell_cnt;
    logic [PW-1:0]    r_pos;
    logic             r_bdir;
    logic             r_fill_q;

    logic [WIDTH-1:0] w_step_led;
    logic             w_step_wrap;
    logic [PW-1:0]    w_step_pos;
    logic             w_step_bdir;
    logic             w_step_fill;
    logic             w_reload;
    logic             w_step;

    function automatic logic [WIDTH-1:0] seed(input mode_t m);
        case (m)
            MODE_BLINK: seed = LED_ONES;
            MODE_FILL:  seed = '0;
            default:    seed = LED_ONE;
        endcase
    endfunction

    assign w_reload = (mode != r_mode_q);
    assign w_step   = en && (r_dwell_cnt == CNT_LAST);

    // Next pattern state for one step of the currently loaded mode.
    always_comb begin
        w_step_led  = r_led;
        w_step_wrap = 1'b0;
        w_step_pos  = r_pos;
        w_step_bdir = r_bdir;
        w_step_fill = r_fill_q;
        case (r_mode_q)
            MODE_BLINK: begin
                w_step_led  = ~r_led;
                w_step_wrap = (r_led == '0);
            end
            MODE_ROTATE: begin
                if (dir)
                    w_step_led = {r_led[0], r_led[WIDTH-1:1]};
                else
                    w_step_led = {r_led[WIDTH-2:0], r_led[WIDTH-1]};
                w_step_wrap = (w_step_led == LED_ONE);
            end
            MODE_BOUNCE: begin
                if (r_bdir == DIR_UP) begin
                    if (r_pos == POS_LAST) begin
                        w_step_bdir = DIR_DOWN;
                        w_step_pos  = POS_LAST - POS_ONE;
                    end else begin
                        w_step_pos  = r_pos + POS_ONE;
                    end
                end else if (r_pos == '0) begin
                    w_step_bdir = DIR_UP;
                    w_step_pos  = POS_ONE;
                end else begin
                    w_step_pos  = r_pos - POS_ONE;
                end
                w_step_led  = LED_ONE << w_step_pos;
                w_step_wrap = (w_step_pos == '0);
            end
            MODE_FILL: begin
                // Turn around at full/empty without repeating the endpoint value.
                if (r_fill_q) begin
                    if (r_led == LED_ONES) begin
                        w_step_fill = 1'b0;
                        w_step_led  = {r_led[WIDTH-2:0], 1'b0};
                    end else begin
                        w_step_led  = {r_led[WIDTH-2:0], 1'b1};
                    end
                end else if (r_led == '0) begin
                    w_step_fill = 1'b1;
                    w_step_led  = {r_led[WIDTH-2:0], 1'b1};
                end else begin
                    w_step_led  = {r_led[WIDTH-2:0], 1'b0};
                end
                w_step_wrap = (w_step_led == '0);
            end
        endcase
    end

    always_ff @(posedge clk_now or posedge rst) begin
        if (rst) begin
            r_led       <= LED_ONES;
            r_wrap      <= 1'b0;
            r_mode_q    <= MODE_BLINK;
            r_dwell_cnt <= '0;
            r_pos       <= '0;
            r_bdir      <= DIR_UP;
            r_fill_q    <= 1'b1;
        end else if (w_reload) begin
            r_mode_q    <= mode;
            r_led       <= seed(mode);
            r_dwell_cnt <= '0;
            r_pos       <= '0;
            r_bdir      <= DIR_UP;
            r_fill_q    <= 1'b1;
            r_wrap      <= 1'b0;
        end else if (w_step) begin
            r_dwell_cnt <= '0;
            r_led       <= w_step_led;
            r_pos       <= w_step_pos;
            r_bdir      <= w_step_bdir;
            r_fill_q    <= w_step_fill;
            r_wrap      <= w_step_wrap;
        end else if (en) begin
            r_dwell_cnt <= r_dwell_cnt + CW'(1);
            r_wrap      <= 1'b0;
        end else begin
            r_wrap      <= 1'b0;
        end
    end

    assign led  = r_led;
    assign wrap = r_wrap;

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - self-checking bench for led_pattern_gen (three parameter sets)
module tb_led_pattern_gen;

    logic        clk_now;
    logic        rst;
    logic        en;
    logic [1:0]  mode;
    logic        dir;
    logic [15:0] led_a;
    logic        wrap_a;
    logic [15:0] led_b;
    logic        wrap_b;
    logic [3:0]  led_c;
    logic        wrap_c;

    int total = 0;
    int bad   = 0;

    led_pattern_gen #(.WIDTH(16), .DWELL(1)) u_a (
        .clk_now(clk_now), .rst(rst), .en(en), .mode(mode), .dir(dir), .led(led_a), .wrap(wrap_a));
    led_pattern_gen #(.WIDTH(16), .DWELL(3)) u_b (
        .clk_now(clk_now), .rst(rst), .en(en), .mode(mode), .dir(dir), .led(led_b), .wrap(wrap_b));
    led_pattern_gen #(.WIDTH(4), .DWELL(1)) u_c (
        .clk_now(clk_now), .rst(rst), .en(en), .mode(mode), .dir(dir), .led(led_c), .wrap(wrap_c));

    initial begin
        clk_now = 1'b0;
        forever #5 clk_now = ~clk_now;
    end

    // Reference model: step index within the pattern period, plus a lit-bit index for rotate.
    int         m_w[3] = '{16, 16, 4};
    int         m_d[3] = '{1, 3, 1};
    logic [1:0] m_mode[3];
    int         m_cnt[3];
    int         m_k[3];
    int         m_rpos[3];
    logic       m_wrap[3];

    function automatic int period(int i);
        case (m_mode[i])
            2'd0:    return 2;
            2'd1:    return m_w[i];
            2'd2:    return 2 * m_w[i] - 2;
            default: return 2 * m_w[i];
        endcase
    endfunction

    function automatic logic [15:0] model_led(int i);
        int w;
        int mask;
        int k;
        int v;
        w    = m_w[i];
        mask = (1 << w) - 1;
        k    = m_k[i];
        case (m_mode[i])
            2'd0:    v = (k == 0) ? mask : 0;
            2'd1:    v = 1 << m_rpos[i];
            2'd2:    v = 1 << ((k < w) ? k : (2 * w - 2 - k));
            default: v = (k <= w) ? ((1 << k) - 1) : (mask & ~((1 << (k - w)) - 1));
        endcase
        return 16'(v);
    endfunction

    function automatic logic [15:0] fill16(int s);
        if (s <= 16) return 16'((1 << s) - 1);
        return 16'(32'hFFFF & ~((1 << (s - 16)) - 1));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_mode[i] = 2'd0;
            m_cnt[i]  = 0;
            m_k[i]    = 0;
            m_rpos[i] = 0;
            m_wrap[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 3; i++) begin
            if (mode != m_mode[i]) begin
                m_mode[i] = mode;
                m_cnt[i]  = 0;
                m_k[i]    = 0;
                m_rpos[i] = 0;
                m_wrap[i] = 1'b0;
            end else if (en && m_cnt[i] == m_d[i] - 1) begin
                m_cnt[i] = 0;
                m_k[i]   = (m_k[i] + 1) % period(i);
                if (m_mode[i] == 2'd1) begin
                    m_rpos[i] = dir ? (m_rpos[i] + m_w[i] - 1) % m_w[i] : (m_rpos[i] + 1) % m_w[i];
                    m_wrap[i] = (m_rpos[i] == 0);
                end else begin
                    m_wrap[i] = (m_k[i] == 0);
                end
            end else begin
                if (en) m_cnt[i] = m_cnt[i] + 1;
                m_wrap[i] = 1'b0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("model_a_led",  led_a,            model_led(0));
        chk("model_a_wrap", {15'b0, wrap_a},  {15'b0, m_wrap[0]});
        chk("model_b_led",  led_b,            model_led(1));
        chk("model_b_wrap", {15'b0, wrap_b},  {15'b0, m_wrap[1]});
        chk("model_c_led",  {12'b0, led_c},   model_led(2));
        chk("model_c_wrap", {15'b0, wrap_c},  {15'b0, m_wrap[2]});
    endtask

    task automatic tick();
        @(posedge clk_now);
        model_edge();
        #1;
        compare_all();
    endtask

    typedef struct {
        logic        en;
        logic [1:0]  mode;
        logic        dir;
        logic [15:0] led;
        logic        wrap;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{1'b1, 2'd0, 1'b0, 16'h0000, 1'b0};
        vecs[1]  = '{1'b1, 2'd0, 1'b0, 16'hFFFF, 1'b1};
        vecs[2]  = '{1'b1, 2'd0, 1'b0, 16'h0000, 1'b0};
        vecs[3]  = '{1'b1, 2'd1, 1'b0, 16'h0001, 1'b0};
        vecs[4]  = '{1'b1, 2'd1, 1'b0, 16'h0002, 1'b0};
        vecs[5]  = '{1'b1, 2'd1, 1'b0, 16'h0004, 1'b0};
        vecs[6]  = '{1'b1, 2'd1, 1'b1, 16'h0002, 1'b0};
        vecs[7]  = '{1'b1, 2'd1, 1'b1, 16'h0001, 1'b1};
        vecs[8]  = '{1'b1, 2'd1, 1'b1, 16'h8000, 1'b0};
        vecs[9]  = '{1'b1, 2'd1, 1'b0, 16'h0001, 1'b1};
        vecs[10] = '{1'b1, 2'd1, 1'b0, 16'h0002, 1'b0};

        rst  = 1'b1;
        en   = 1'b1;
        mode = 2'd0;
        dir  = 1'b0;
        model_reset();
        #1;
        chk("reset_a_led",  led_a,           16'hFFFF);
        chk("reset_a_wrap", {15'b0, wrap_a}, 16'h0000);
        chk("reset_c_led",  {12'b0, led_c},  16'h000F);
        compare_all();
        tick();
        rst = 1'b0;

        // Blink and rotate, including a mid-run direction reversal.
        for (int i = 0; i < 11; i++) begin
            en   = vecs[i].en;
            mode = vecs[i].mode;
            dir  = vecs[i].dir;
            tick();
            chk($sformatf("vec%0d_led", i),  led_a,           vecs[i].led);
            chk($sformatf("vec%0d_wrap", i), {15'b0, wrap_a}, {15'b0, vecs[i].wrap});
        end

        // Bounce: endpoints are visited once, wrap on return to bit 0.
        mode = 2'd2;
        dir  = 1'b0;
        tick();
        chk("bounce_seed", led_a, 16'h0001);
        for (int s = 1; s <= 30; s++) begin
            int p;
            p = (s <= 15) ? s : 30 - s;
            tick();
            chk($sformatf("bounce%0d_led", s),  led_a,           16'(1 << p));
            chk($sformatf("bounce%0d_wrap", s), {15'b0, wrap_a}, {15'b0, 1'(s == 30)});
        end

        // Fill/drain with three-tick dwell on instance b.
        mode = 2'd3;
        tick();
        chk("fill_seed", led_b, 16'h0000);
        for (int s = 1; s <= 32; s++) begin
            for (int e = 0; e < 3; e++) begin
                tick();
                chk($sformatf("fill%0d_%0d_led", s, e), led_b, (e == 2) ? fill16(s) : fill16(s - 1));
                chk($sformatf("fill%0d_%0d_wrap", s, e), {15'b0, wrap_b}, {15'b0, 1'(e == 2 && s == 32)});
            end
        end

        // Freeze mid-dwell, then resume for the remaining dwell only.
        repeat (3) tick();
        chk("fill_restart", led_b, 16'h0001);
        tick();
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("freeze_led",  led_b,           16'h0001);
            chk("freeze_wrap", {15'b0, wrap_b}, 16'h0000);
        end
        en = 1'b1;
        tick();
        chk("resume_hold", led_b, 16'h0001);
        tick();
        chk("resume_step", led_b, 16'h0003);
        en   = 1'b0;
        mode = 2'd0;
        tick();
        chk("reload_en0", led_b, 16'hFFFF);
        tick();
        chk("reload_en0_hold", led_b, 16'hFFFF);

        // Asynchronous reset between edges on the 4-LED instance.
        en   = 1'b1;
        mode = 2'd2;
        repeat (3) tick();
        chk("c_bounce", {12'b0, led_c}, 16'h0004);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_c_led",  {12'b0, led_c},  16'h000F);
        chk("async_c_wrap", {15'b0, wrap_c}, 16'h0000);
        chk("async_a_led",  led_a,           16'hFFFF);
        rst = 1'b0;
        tick();
        chk("c_after_reset", {12'b0, led_c}, 16'h0001);
        tick();
        chk("c_after_reset2", {12'b0, led_c}, 16'h0002);

        // Randomised run against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(29) == 0) mode = 2'($urandom_range(3));
            en = ($urandom_range(4) != 0);
            if ($urandom_range(7) == 0) dir = ~dir;
            if ($urandom_range(149) == 0) begin
                #1;
                rst = 1'b1;
                model_reset();
                #1;
                compare_all();
                rst = 1'b0;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
